// File: rtl/tmds_encoder_if.sv
// Pixel-side bus for one TMDS lane:
// raw pixel/control in, encoded symbol out.
interface tmds_encoder_if;
  logic [7:0] in_data;
  logic [1:0] in_c;
  logic       in_blank;
  logic [9:0] out_tmds;
  logic       out_blank;

  modport master (
    output in_data, in_c, in_blank,
    input  out_tmds, out_blank
  );

  modport slave (
    input  in_data, in_c, in_blank,
    output out_tmds, out_blank
  );
endinterface

// File: rtl/tmds_encoder.sv
// DVI TMDS 8b/10b lane encoder: transition
// minimisation then DC balance, one symbol/clock.
module tmds_encoder #(
  parameter int C_in_reg   = 1,
  parameter int C_cnt_bits = 5
) (
  input  logic          clk_pixel,
  input  logic          reset,
  tmds_encoder_if.slave bus
);
  localparam int W = C_cnt_bits;
  localparam logic [9:0] TOK00 = 10'b1101010100;

  logic [7:0] a_data;
  logic [1:0] a_c;
  logic       a_blank;

  if (C_in_reg != 0) begin : g_in_reg
    logic [7:0] data_q;
    logic [1:0] c_q;
    logic       blank_q;

    always_ff @(posedge clk_pixel) begin
      if (reset) begin
        data_q  <= '0;
        c_q     <= '0;
        blank_q <= 1'b1;
      end else begin
        data_q  <= bus.in_data;
        c_q     <= bus.in_c;
        blank_q <= bus.in_blank;
      end
    end

    assign a_data  = data_q;
    assign a_c     = c_q;
    assign a_blank = blank_q;
  end else begin : g_no_in_reg
    assign a_data  = bus.in_data;
    assign a_c     = bus.in_c;
    assign a_blank = bus.in_blank;
  end

  // Stage A: transition minimisation
  logic [3:0] ones_d;
  logic       xnor_d;
  logic [8:0] qm_d;
  logic [3:0] n1_d;

  always_comb begin
    ones_d = '0;
    for (int i = 0; i < 8; i++)
      ones_d = ones_d + {3'b000, a_data[i]};
    xnor_d = (ones_d > 4'd4) ||
             (ones_d == 4'd4 && !a_data[0]);
    qm_d    = '0;
    qm_d[0] = a_data[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = xnor_d ? ~(qm_d[i-1] ^ a_data[i])
                       :  (qm_d[i-1] ^ a_data[i]);
    qm_d[8] = ~xnor_d;
    n1_d = '0;
    for (int i = 0; i < 8; i++)
      n1_d = n1_d + {3'b000, qm_d[i]};
  end

  logic [8:0] qm_q;
  logic [3:0] n1_q;
  logic [1:0] c_a_q;
  logic       blank_a_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      qm_q      <= '0;
      n1_q      <= '0;
      c_a_q     <= '0;
      blank_a_q <= 1'b1;
    end else begin
      qm_q      <= qm_d;
      n1_q      <= n1_d;
      c_a_q     <= a_c;
      blank_a_q <= a_blank;
    end
  end

  // Stage B: DC balance
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] disp;
  logic [W-1:0] q8x2;
  logic [W-1:0] nq8x2;
  logic [9:0]   tmds_q, tmds_d;
  logic [9:0]   token;
  logic         blank_q;
  logic         q8;
  logic         cnt_zero, cnt_neg, cnt_pos;
  logic         sel_blank, sel_bal;
  logic         sel_inv, sel_keep;

  always_comb begin
    q8    = qm_q[8];
    disp  = W'({n1_q, 1'b0}) - W'(8);
    q8x2  = q8 ? W'(2) : '0;
    nq8x2 = q8 ? '0 : W'(2);

    cnt_zero = (cnt_q == '0);
    cnt_neg  = cnt_q[W-1];
    cnt_pos  = !cnt_neg && !cnt_zero;

    sel_blank = blank_a_q;
    sel_bal   = !blank_a_q &&
                (cnt_zero || n1_q == 4'd4);
    sel_inv   = !blank_a_q && !sel_bal &&
                ((cnt_pos && n1_q > 4'd4) ||
                 (cnt_neg && n1_q < 4'd4));
    sel_keep  = !blank_a_q && !sel_bal && !sel_inv;

    case (c_a_q)
      2'b00:   token = TOK00;
      2'b01:   token = 10'b0010101011;
      2'b10:   token = 10'b0101010100;
      default: token = 10'b1010101011;
    endcase

    tmds_d = token;
    cnt_d  = '0;
    unique case (1'b1)
      sel_blank: begin
        tmds_d = token;
        cnt_d  = '0;
      end
      sel_bal: begin
        tmds_d = {~q8, q8,
                  q8 ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d  = q8 ? cnt_q + disp
                    : cnt_q - disp;
      end
      sel_inv: begin
        tmds_d = {1'b1, q8, ~qm_q[7:0]};
        cnt_d  = cnt_q + q8x2 - disp;
      end
      sel_keep: begin
        tmds_d = {1'b0, q8, qm_q[7:0]};
        cnt_d  = cnt_q + disp - nq8x2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds_q  <= TOK00;
      blank_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      tmds_q  <= tmds_d;
      blank_q <= blank_a_q;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_tmds  = tmds_q;
  assign bus.out_blank = blank_q;
endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder:
// directed tokens/disparity/reset, then random.
module tb_tmds_encoder;
  localparam int C_IN_REG = 1;
  localparam int L = 2 + C_IN_REG;
  localparam logic [9:0] TOK00 = 10'h354;

  typedef struct {
    logic [10:0] exp;
    bit          is_data;
    logic [7:0]  data;
  } sb_t;

  logic clk;
  logic rst;
  tmds_encoder_if bus ();

  tmds_encoder #(
    .C_in_reg  (C_IN_REG),
    .C_cnt_bits(5)
  ) dut (
    .clk_pixel(clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sb_t sbq[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  mcnt = 0;
  int  run = 0;

  task automatic chk(input string tag,
                     input logic [10:0] obs,
                     input logic [10:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s got %h exp %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model(
    input logic [7:0] d,
    input logic [1:0] c,
    input logic b);
    int n1, nq1, nq0, q8;
    logic xn;
    logic [8:0] qm;
    logic [9:0] o;
    if (b) begin
      mcnt = 0;
      case (c)
        2'b00: return 10'b1101010100;
        2'b01: return 10'b0010101011;
        2'b10: return 10'b0101010100;
        default: return 10'b1010101011;
      endcase
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ d[i])
                 : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    q8  = qm[8] ? 1 : 0;
    nq1 = $countones(qm[7:0]);
    nq0 = 8 - nq1;
    if (mcnt == 0 || nq1 == nq0) begin
      o = {~qm[8], qm[8],
           qm[8] ? qm[7:0] : ~qm[7:0]};
      mcnt += q8 ? (nq1 - nq0) : (nq0 - nq1);
    end else if ((mcnt > 0 && nq1 > nq0) ||
                 (mcnt < 0 && nq0 > nq1)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      mcnt += 2 * q8 + nq0 - nq1;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      mcnt += nq1 - nq0 - 2 * (1 - q8);
    end
    return o;
  endfunction

  function automatic logic [7:0] decode(
    input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (q[i] ^ q[i-1])
                  : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic check_out();
    sb_t e;
    logic [9:0] s;
    if (sbq.size() == 0) begin
      chk("sb_empty", 11'h0, 11'h7FF);
      return;
    end
    e = sbq.pop_front();
    s = bus.out_tmds;
    chk("sym", {bus.out_blank, s}, e.exp);
    if (bus.out_blank) begin
      run = 0;
    end else begin
      run += 2 * $countones(s) - 10;
      chk("disp_bound",
          {10'h0, (run <= 10 && run >= -10)},
          11'h1);
    end
    if (e.is_data)
      chk("decode", {3'b0, decode(s)},
          {3'b0, e.data});
  endtask

  task automatic step(input logic [7:0] d,
                      input logic [1:0] c,
                      input logic b,
                      input bit use_k,
                      input logic [9:0] k);
    sb_t e;
    logic [9:0] m;
    @(negedge clk);
    rst = 1'b0;
    bus.in_data  = d;
    bus.in_c     = c;
    bus.in_blank = b;
    m = model(d, c, b);
    e.exp     = {b, use_k ? k : m};
    e.is_data = !b;
    e.data    = d;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset(input int n,
                          input logic [7:0] d);
    sb_t t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.in_data  = d;
      bus.in_c     = 2'b11;
      bus.in_blank = 1'b0;
      @(posedge clk);
      #1;
      chk("reset",
          {bus.out_blank, bus.out_tmds},
          {1'b1, TOK00});
    end
    sbq.delete();
    t.exp     = {1'b1, TOK00};
    t.is_data = 1'b0;
    t.data    = '0;
    for (int i = 0; i < L - 1; i++)
      sbq.push_back(t);
    mcnt = 0;
    run  = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_data  = 8'hAA;
    bus.in_c     = 2'b00;
    bus.in_blank = 1'b0;

    do_reset(3, 8'hAA);

    step(8'hFF, 2'b00, 1'b1, 1, 10'h354);
    step(8'hFF, 2'b01, 1'b1, 1, 10'h0AB);
    step(8'hFF, 2'b10, 1'b1, 1, 10'h154);
    step(8'hFF, 2'b11, 1'b1, 1, 10'h2AB);

    step(8'h00, 2'b11, 1'b0, 1, 10'h100);
    step(8'h00, 2'b11, 1'b0, 1, 10'h3FF);
    step(8'h00, 2'b11, 1'b0, 1, 10'h100);
    for (int i = 0; i < 7; i++)
      step(8'h00, 2'b00, 1'b0, 0, 10'h0);

    step(8'h5A, 2'b00, 1'b1, 1, 10'h354);
    step(8'h00, 2'b00, 1'b0, 1, 10'h100);
    step(8'h00, 2'b00, 1'b0, 1, 10'h3FF);
    step(8'h00, 2'b00, 1'b0, 1, 10'h100);
    step(8'hC3, 2'b00, 1'b1, 1, 10'h354);
    step(8'h00, 2'b00, 1'b0, 1, 10'h100);

    step(8'h37, 2'b00, 1'b0, 0, 10'h0);
    step(8'hE1, 2'b00, 1'b0, 0, 10'h0);
    do_reset(1, 8'h55);
    step(8'h00, 2'b00, 1'b0, 1, 10'h100);
    step(8'h00, 2'b00, 1'b0, 1, 10'h3FF);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rd;
      logic [1:0] rc;
      logic       rb;
      rd = 8'($urandom);
      rc = 2'($urandom);
      rb = ($urandom_range(0, 7) == 0);
      step(rd, rc, rb, 0, 10'h0);
    end

    for (int i = 0; i < L; i++)
      step(8'h00, 2'b00, 1'b1, 1, 10'h354);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
